dram_rd_arb: RTL and testbench

- Shares the single data-RAM read port between two requesters: port A (load unit, 32-bit word reads) and port B (byte reader, e.g. boot/debug DMA).
- Performs round-robin arbitration, drives the RAM read-select and address, and tracks the RAM's 1-cycle read latency.
- Returns each result only to its own requester, with a registered byte-lane select for port B.
- Forwards same-cycle RAM writes into the returned data, so reads never see stale words.

---
 rtl/dram_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 37 +++
 rtl/dram_rd_arb.sv | 114 +++++++++++
 tb/tb_dram_rd_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// ============================================================================
// Module : dram_pkg
// Brief  : Shared encodings and byte-merge helper for data-RAM read logic.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef logic [1:0] lane_t;

  // Replace every enabled byte of word with the matching byte of wdata.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] word,
    input logic [WORD_W-1:0] wdata,
    input logic [3:0]        byte_en
  );
    logic [WORD_W-1:0] res;
    res = word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-input round-robin arbiter; index 0 = port A, index 1 = port B.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import dram_pkg::*;
#(
  parameter bit B_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic r_ptr;  // 1 = port B has priority on a tie

  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      if (req == 2'b11) grant[r_ptr] = 1'b1;
      else              grant        = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= B_FIRST;
    else if (|grant) r_ptr <= grant[0];
  end

endmodule

`default_nettype wire

// File: rtl/dram_rd_arb.sv
// ============================================================================
// Module : dram_rd_arb
// Brief  : Round-robin sharing of the data-RAM read port between A and B,
//          with 1-cycle return and same-cycle write forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_rd_arb
  import dram_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          B_FIRST = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            a_req_i,
  input  logic [XLEN-1:0] a_addr_i,
  output logic            a_gnt_o,
  output logic            a_rvalid_o,
  output logic [XLEN-1:0] a_rdata_o,
  input  logic            b_req_i,
  input  logic [XLEN-1:0] b_addr_i,
  output logic            b_gnt_o,
  output logic            b_rvalid_o,
  output logic [7:0]      b_rdata_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [3:0]      wr_byte_en_i,
  output logic            ram_rd_sel_o,
  output logic [XLEN-1:0] ram_rd_addr_o,
  input  logic [XLEN-1:0] ram_rd_data_i
);

  logic [1:0]      w_grant;
  logic            w_sel;
  logic            w_hit;
  logic [XLEN-1:0] w_merged;
  logic [7:0]      w_byte;
  logic            w_unused_lsb;

  logic            r_sel;
  logic            r_a_pend;
  logic            r_b_pend;
  lane_t           r_lane;
  logic [3:0]      r_fwd_be;
  logic [XLEN-1:0] r_fwd_data;
  logic [XLEN-1:0] r_a_data;
  logic [7:0]      r_b_data;

  // Reset blocks grants so nothing is accepted while the pipeline is cleared.
  rr_arb2 #(
    .B_FIRST (B_FIRST)
  ) u_arb (
    .clk   (clk_i),
    .rst   (rst_i),
    .hold  (hold_i | rst_i),
    .req   ({b_req_i, a_req_i}),
    .grant (w_grant)
  );

  assign a_gnt_o = w_grant[0];
  assign b_gnt_o = w_grant[1];

  always_comb begin
    w_sel = r_sel;
    if (a_gnt_o)      w_sel = SEL_A;
    else if (b_gnt_o) w_sel = SEL_B;
  end

  assign ram_rd_sel_o  = w_sel;
  assign ram_rd_addr_o = (w_sel == SEL_A) ? a_addr_i : b_addr_i;

  // Write landing in the grant cycle is invisible to the RAM read; capture it.
  assign w_hit        = wr_en_i && (wr_addr_i[XLEN-1:2] == ram_rd_addr_o[XLEN-1:2]);
  assign w_unused_lsb = ^wr_addr_i[1:0];

  assign w_merged = byte_merge(ram_rd_data_i, r_fwd_data, r_fwd_be);
  assign w_byte   = w_merged[{r_lane, 3'b000} +: 8];

  assign a_rvalid_o = r_a_pend;
  assign b_rvalid_o = r_b_pend;
  assign a_rdata_o  = r_a_pend ? w_merged : r_a_data;
  assign b_rdata_o  = r_b_pend ? w_byte   : r_b_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel      <= SEL_A;
      r_a_pend   <= 1'b0;
      r_b_pend   <= 1'b0;
      r_lane     <= '0;
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
      r_a_data   <= '0;
      r_b_data   <= '0;
    end else begin
      r_sel    <= w_sel;
      r_a_pend <= a_gnt_o;
      r_b_pend <= b_gnt_o;
      if (|w_grant) begin
        r_lane     <= b_addr_i[1:0];
        r_fwd_be   <= w_hit ? wr_byte_en_i : 4'b0000;
        r_fwd_data <= wr_data_i;
      end
      if (r_a_pend) r_a_data <= w_merged;
      if (r_b_pend) r_b_data <= w_byte;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_rd_arb.sv
// ============================================================================
// Module : tb_dram_rd_arb
// Brief  : Self-checking bench for dram_rd_arb with a small RAM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_rd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_gnt, b_gnt, a_rv, b_rv;
  logic [31:0] a_rdata;
  logic [7:0]  b_rdata;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic        rd_sel;
  logic [31:0] rd_addr, ram_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dram_rd_arb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .hold_i        (hold),
    .a_req_i       (a_req),
    .a_addr_i      (a_addr),
    .a_gnt_o       (a_gnt),
    .a_rvalid_o    (a_rv),
    .a_rdata_o     (a_rdata),
    .b_req_i       (b_req),
    .b_addr_i      (b_addr),
    .b_gnt_o       (b_gnt),
    .b_rvalid_o    (b_rv),
    .b_rdata_o     (b_rdata),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_byte_en_i  (wr_be),
    .ram_rd_sel_o  (rd_sel),
    .ram_rd_addr_o (rd_addr),
    .ram_rd_data_i (ram_q)
  );

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  // Synchronous-read RAM: a read and a write to the same word in one cycle return the old word.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    ram_q <= mem[rd_addr[5:2]];
    if (wr_en) mem[wr_addr[5:2]] <= ref_merge(mem[wr_addr[5:2]], wr_data, wr_be);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hold = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = 4'hF;
    tick();
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic [31:0] b_addr;
    logic        hold;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        e_ag, e_bg, e_arv, e_brv;
    logic [31:0] e_ad;
    logic [7:0]  e_bd;
  } vec_t;

  vec_t tbl [10];

  // Reference model state for the randomized phase
  logic [31:0] model_mem [0:15];
  logic        m_ptr_b, m_sel, eg_a, eg_b, exp_sel;
  logic [31:0] ma_data, word, g_addr;
  logic [7:0]  mb_data;
  logic        ra, rb;
  logic [31:0] raddr_a, raddr_b;

  initial begin
    tbl[0] = '{1'b1, 32'h10, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 8'h00};
    tbl[1] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF,
               1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 8'h00};
    tbl[2] = '{1'b0, 32'h0,  1'b1, 32'h13, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'h11};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'h44};
    tbl[4] = '{1'b1, 32'h20, 1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 32'h55555555, 4'h5,
               1'b1, 1'b0, 1'b1, 1'b0, 32'hAA55AA55, 8'h44};
    tbl[5] = '{1'b1, 32'h20, 1'b0, 32'h0,  1'b0, 1'b1, 32'h20, 32'h77000000, 4'h8,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h7755AA55, 8'h44};
    tbl[6] = '{1'b1, 32'h10, 1'b1, 32'h21, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 32'h7755AA55, 8'hAA};
    tbl[7] = '{1'b1, 32'h10, 1'b1, 32'h22, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 32'h11223344, 8'hAA};
    tbl[8] = '{1'b1, 32'h10, 1'b1, 32'h22, 1'b1, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h11223344, 8'hAA};
    tbl[9] = '{1'b1, 32'h10, 1'b1, 32'h22, 1'b0, 1'b0, 32'h0,  32'h0,        4'h0,
               1'b0, 1'b1, 1'b0, 1'b1, 32'h11223344, 8'h55};

    // Reset state
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst a_gnt", 32'(a_gnt), 32'd0);
    chk("rst b_gnt", 32'(b_gnt), 32'd0);
    chk("rst a_rvalid", 32'(a_rv), 32'd0);
    chk("rst b_rvalid", 32'(b_rv), 32'd0);
    chk("rst a_rdata", a_rdata, 32'd0);
    chk("rst b_rdata", 32'(b_rdata), 32'd0);
    chk("rst rd_sel", 32'(rd_sel), 32'd1);
    rst = 1'b0;

    ram_write(32'h10, 32'hDEADBEEF);
    ram_write(32'h20, 32'hAAAAAAAA);

    // Directed vector table, one cycle per entry
    for (int i = 0; i < 10; i++) begin
      a_req = tbl[i].a_req;  a_addr = tbl[i].a_addr;
      b_req = tbl[i].b_req;  b_addr = tbl[i].b_addr;
      hold  = tbl[i].hold;   wr_en  = tbl[i].wr_en;
      wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data; wr_be = tbl[i].wr_be;
      #1;
      chk($sformatf("v%0d a_gnt", i), 32'(a_gnt), 32'(tbl[i].e_ag));
      chk($sformatf("v%0d b_gnt", i), 32'(b_gnt), 32'(tbl[i].e_bg));
      tick();
      chk($sformatf("v%0d a_rvalid", i), 32'(a_rv), 32'(tbl[i].e_arv));
      chk($sformatf("v%0d b_rvalid", i), 32'(b_rv), 32'(tbl[i].e_brv));
      chk($sformatf("v%0d a_rdata", i), a_rdata, tbl[i].e_ad);
      chk($sformatf("v%0d b_rdata", i), 32'(b_rdata), 32'(tbl[i].e_bd));
    end

    // Continuous requests from both after reset alternate A,B,A,B...
    do_reset();
    a_req = 1'b1; a_addr = 32'h10; b_req = 1'b1; b_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("alt%0d a_gnt", i), 32'(a_gnt), 32'((i % 2) == 0));
      chk($sformatf("alt%0d b_gnt", i), 32'(b_gnt), 32'((i % 2) == 1));
      tick();
      chk($sformatf("alt%0d a_rvalid", i), 32'(a_rv), 32'((i % 2) == 0));
      chk($sformatf("alt%0d b_rvalid", i), 32'(b_rv), 32'((i % 2) == 1));
    end

    // Point the pointer at B, then hold with both requesting
    b_req = 1'b0;
    tick();
    b_req = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d gnt", i), {30'b0, b_gnt, a_gnt}, 32'd0);
      tick();
      chk($sformatf("hold%0d rvalid", i), {30'b0, b_rv, a_rv}, 32'd0);
    end
    hold = 1'b0;
    #1;
    chk("release b_gnt", 32'(b_gnt), 32'd1);
    chk("release a_gnt", 32'(a_gnt), 32'd0);
    tick();
    chk("release b_rvalid", 32'(b_rv), 32'd1);

    // Reset arriving the cycle after an A grant discards that read
    b_req = 1'b0; a_req = 1'b1; a_addr = 32'h10;
    #1;
    chk("midrst a_gnt", 32'(a_gnt), 32'd1);
    tick();
    rst = 1'b1; b_req = 1'b1;
    #1;
    chk("midrst gnt blocked", {30'b0, b_gnt, a_gnt}, 32'd0);
    tick();
    chk("midrst a_rvalid", 32'(a_rv), 32'd0);
    chk("midrst b_rvalid", 32'(b_rv), 32'd0);
    chk("midrst a_rdata", a_rdata, 32'd0);
    chk("midrst b_rdata", 32'(b_rdata), 32'd0);
    chk("midrst rd_sel", 32'(rd_sel), 32'd1);
    tick();
    chk("midrst a_rvalid2", 32'(a_rv), 32'd0);
    rst = 1'b0;

    // Randomized phase against the reference model
    do_reset();
    for (int w = 0; w < 16; w++) begin
      model_mem[w] = $urandom;
      ram_write(32'(w * 4), model_mem[w]);
    end
    m_ptr_b = 1'b0; m_sel = 1'b1; ma_data = '0; mb_data = '0;
    ra = 1'b0; rb = 1'b0; raddr_a = '0; raddr_b = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ra) begin ra = ($urandom % 3) != 0; raddr_a = {26'b0, 6'($urandom)}; end
      if (!rb) begin rb = ($urandom % 3) != 0; raddr_b = {26'b0, 6'($urandom)}; end
      a_req = ra; a_addr = raddr_a; b_req = rb; b_addr = raddr_b;
      hold    = ($urandom % 5) == 0;
      wr_en   = 1'($urandom % 2);
      wr_addr = {26'b0, 6'($urandom)};
      wr_data = $urandom;
      wr_be   = 4'($urandom);
      #1;
      eg_a = 1'b0; eg_b = 1'b0;
      if (!hold) begin
        if (ra && rb) begin eg_a = !m_ptr_b; eg_b = m_ptr_b; end
        else begin eg_a = ra; eg_b = rb; end
      end
      exp_sel = eg_a ? 1'b1 : (eg_b ? 1'b0 : m_sel);
      chk($sformatf("rnd%0d a_gnt", c), 32'(a_gnt), 32'(eg_a));
      chk($sformatf("rnd%0d b_gnt", c), 32'(b_gnt), 32'(eg_b));
      chk($sformatf("rnd%0d rd_sel", c), 32'(rd_sel), 32'(exp_sel));
      chk($sformatf("rnd%0d rd_addr", c), rd_addr, exp_sel ? raddr_a : raddr_b);
      if (eg_a || eg_b) begin
        g_addr = eg_a ? raddr_a : raddr_b;
        word = model_mem[g_addr[5:2]];
        if (wr_en && wr_addr[31:2] == g_addr[31:2]) word = ref_merge(word, wr_data, wr_be);
        if (eg_a) ma_data = word;
        if (eg_b) mb_data = 8'(word >> (8 * g_addr[1:0]));
        m_ptr_b = eg_a;
      end
      if (wr_en) model_mem[wr_addr[5:2]] = ref_merge(model_mem[wr_addr[5:2]], wr_data, wr_be);
      m_sel = exp_sel;
      if (eg_a) ra = 1'b0;
      if (eg_b) rb = 1'b0;
      tick();
      chk($sformatf("rnd%0d a_rvalid", c), 32'(a_rv), 32'(eg_a));
      chk($sformatf("rnd%0d b_rvalid", c), 32'(b_rv), 32'(eg_b));
      chk($sformatf("rnd%0d a_rdata", c), a_rdata, ma_data);
      chk($sformatf("rnd%0d b_rdata", c), 32'(b_rdata), 32'(mb_data));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
